weight_fetch_controller: RTL and testbench

//  Weight-side sequencer for the Winograd conv engine. The main controller requests a weight set:

---
 rtl/weight_fetch_controller.sv | 154 +++++++++++++++
 tb/tb_weight_fetch_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_controller.sv
// Weight fetch sequencer: loads two 3x3 kernels (od1, od2 at input depth id)
// from the weight SRAM into local banks and presents them to the PE array.
module weight_fetch_controller #(
   parameter int DATA_W = 8,
   parameter int KWORDS = 9,
   parameter int ADDR_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [3:0]               total_id_i,
   input  logic [7:0]               total_od_i,
   input  logic                     prepare_i,
   input  logic                     start_i,
   input  logic [7:0]               od1_i,
   input  logic [7:0]               od2_i,
   input  logic [3:0]               id_i,
   output logic                     mem_rd_en_o,
   output logic [ADDR_W-1:0]        mem_addr_o,
   input  logic [DATA_W-1:0]        mem_rdata_i,
   input  logic                     mem_rvalid_i,
   output logic                     weight_ready_o,
   output logic                     weight_valid_o,
   output logic [KWORDS*DATA_W-1:0] w1_o,
   output logic [KWORDS*DATA_W-1:0] w2_o,
   output logic                     err_o
);

   localparam int CNT_W = $clog2(2*KWORDS+1);
   localparam int IDX_W = $clog2(KWORDS);
   localparam logic [CNT_W-1:0] K_C  = CNT_W'(KWORDS);
   localparam logic [CNT_W-1:0] K2_C = CNT_W'(2*KWORDS);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, READY, ACTIVE} state_t;

   state_t                        state;
   logic [ADDR_W-1:0]             base1, base2;
   logic [ADDR_W-1:0]             base1_c, base2_c;
   logic                          skip2;
   logic [CNT_W-1:0]              issue_cnt, wr_cnt, outst, outst_next, n_reads;
   logic [IDX_W-1:0]              slot;
   logic                          accept, stray, bad_start;
   logic [KWORDS-1:0][DATA_W-1:0] bank1, bank2;

   assign w1_o = bank1;
   assign w2_o = bank2;

   // Kernel base address: kernels are laid out od-major, id-minor, KWORDS words each
   assign base1_c = ADDR_W'((32'(od1_i) * 32'(total_id_i) + 32'(id_i)) * 32'(KWORDS));
   assign base2_c = ADDR_W'((32'(od2_i) * 32'(total_id_i) + 32'(id_i)) * 32'(KWORDS));

   assign n_reads   = skip2 ? K_C : K2_C;
   // A return only counts if a read is actually outstanding
   assign accept    = mem_rvalid_i && (outst != '0);
   assign stray     = mem_rvalid_i && (outst == '0);
   assign bad_start = start_i && (state == IDLE || state == FETCH || state == DRAIN);

   // Outstanding count after this edge and bank slot of the current return
   always_comb begin
      outst_next = outst + {{(CNT_W-1){1'b0}}, mem_rd_en_o} - {{(CNT_W-1){1'b0}}, accept};
      slot       = (wr_cnt < K_C) ? IDX_W'(wr_cnt) : IDX_W'(wr_cnt - K_C);
   end

   // Outstanding-read counter: request leaves on rd_en, returns on rvalid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) outst <= '0;
      else       outst <= outst_next;
   end

   // Sticky protocol error: stray return data or start outside READY/ACTIVE
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  err_o <= 1'b0;
      else if (stray || bad_start) err_o <= 1'b1;
   end

   // Main sequencer with registered SRAM strobe, status flags and banks
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         base1          <= '0;
         base2          <= '0;
         skip2          <= 1'b0;
         issue_cnt      <= '0;
         wr_cnt         <= '0;
         mem_rd_en_o    <= 1'b0;
         mem_addr_o     <= '0;
         weight_ready_o <= 1'b0;
         weight_valid_o <= 1'b0;
         bank1          <= '0;
         bank2          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (prepare_i) begin
                  base1     <= base1_c;
                  base2     <= base2_c;
                  skip2     <= (od2_i >= total_od_i);
                  issue_cnt <= '0;
                  wr_cnt    <= '0;
                  state     <= FETCH;
               end
            end
            FETCH: begin
               if (!prepare_i) begin
                  // Abort: stop issuing; in-flight returns are drained, not written
                  mem_rd_en_o <= 1'b0;
                  state       <= (outst_next == '0) ? IDLE : DRAIN;
               end else begin
                  if (issue_cnt < n_reads) begin
                     mem_rd_en_o <= 1'b1;
                     mem_addr_o  <= (issue_cnt < K_C) ? base1 + ADDR_W'(issue_cnt)
                                                      : base2 + ADDR_W'(issue_cnt - K_C);
                     issue_cnt   <= issue_cnt + ONE;
                  end else begin
                     mem_rd_en_o <= 1'b0;
                  end
                  if (accept) begin
                     if (wr_cnt < K_C) bank1[slot] <= mem_rdata_i;
                     else              bank2[slot] <= mem_rdata_i;
                     wr_cnt <= wr_cnt + ONE;
                     if (wr_cnt == n_reads - ONE) begin
                        if (skip2) bank2 <= '0;
                        weight_ready_o <= 1'b1;
                        state          <= READY;
                     end
                  end
               end
            end
            DRAIN: begin
               if (outst_next == '0) state <= IDLE;
            end
            READY: begin
               // start has priority over a still-high prepare
               if (start_i) begin
                  weight_ready_o <= 1'b0;
                  weight_valid_o <= 1'b1;
                  state          <= ACTIVE;
               end else if (!prepare_i) begin
                  weight_ready_o <= 1'b0;
                  state          <= IDLE;
               end
            end
            ACTIVE: begin
               if (!start_i) begin
                  weight_valid_o <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_fetch_controller.sv
// Bench for weight_fetch_controller: directed and randomized fetches against a
// behavioural SRAM-content model and address/latency rules.
module tb_weight_fetch_controller;
   localparam int DW = 8, KW = 9, AW = 16, BW = KW*DW;

   logic          clk = 1'b0, reset = 1'b1;
   logic [3:0]    total_id = '0, id = '0;
   logic [7:0]    total_od = '0, od1 = '0, od2 = '0;
   logic          prepare = 1'b0, start = 1'b0;
   logic          mem_rd_en, mem_rvalid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;
   logic          weight_ready, weight_valid, err;
   logic [BW-1:0] w1, w2;

   int            n_checks = 0, n_errors = 0;
   int unsigned   mem_mul = 1, mem_add = 0;
   logic          stray_rv = 1'b0, sram_rv;
   logic [DW-1:0] sram_rd;
   logic          exp_err = 1'b0;

   always #5 clk = ~clk;

   weight_fetch_controller dut (
      .clk(clk), .reset(reset), .total_id_i(total_id), .total_od_i(total_od),
      .prepare_i(prepare), .start_i(start), .od1_i(od1), .od2_i(od2), .id_i(id),
      .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
      .mem_rvalid_i(mem_rvalid), .weight_ready_o(weight_ready),
      .weight_valid_o(weight_valid), .w1_o(w1), .w2_o(w2), .err_o(err));

   // SRAM contents are a simple affine function of the address
   function automatic logic [DW-1:0] mem_word(input int unsigned a);
      return DW'(a * mem_mul + mem_add);
   endfunction

   // One-cycle-latency SRAM read port
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sram_rv <= 1'b0;
         sram_rd <= '0;
      end else begin
         sram_rv <= mem_rd_en;
         sram_rd <= mem_rd_en ? mem_word(32'(mem_addr)) : '0;
      end
   end
   assign mem_rvalid = sram_rv | stray_rv;
   assign mem_rdata  = sram_rd;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] exp_bank(input int unsigned base, input bit zero);
      logic [BW-1:0] b = '0;
      for (int k = 0; k < KW; k++) if (!zero) b[k*DW +: DW] = mem_word(base + k);
      return b;
   endfunction

   function automatic int unsigned kbase(input int od_n, input int tid, input int idd);
      return ((od_n * tid + idd) * KW) & 32'hFFFF;
   endfunction

   // Full fetch: prepare sampled at edge 0, ready expected at reads+2
   task automatic do_fetch(input int tid, tod, o1, o2, idd, input string tag);
      int unsigned b1, b2, addrs[$];
      bit skip;
      int nexp, got;
      b1 = kbase(o1, tid, idd);
      b2 = kbase(o2, tid, idd);
      skip = (o2 >= tod);
      nexp = skip ? KW : 2*KW;
      @(negedge clk);
      total_id = 4'(tid); total_od = 8'(tod);
      od1 = 8'(o1); od2 = 8'(o2); id = 4'(idd);
      prepare = 1'b1;
      @(posedge clk);
      got = -1;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         if (mem_rd_en) addrs.push_back(32'(mem_addr));
         if (weight_ready) begin got = n; break; end
      end
      check({tag, " ready cycle"}, got, nexp + 2);
      check({tag, " read count"}, addrs.size(), nexp);
      for (int j = 0; j < addrs.size() && j < nexp; j++)
         check($sformatf("%s addr%0d", tag, j), addrs[j], (j < KW) ? b1 + j : b2 + j - KW);
      check({tag, " w1"}, w1, exp_bank(b1, 1'b0));
      check({tag, " w2"}, w2, exp_bank(b2, skip));
      check({tag, " valid"}, weight_valid, 1'b0);
      check({tag, " err"}, err, exp_err);
   endtask

   // Hold start for ncyc cycles from READY, then drop start and prepare
   task automatic do_active(input int ncyc, input string tag);
      logic [BW-1:0] s1, s2;
      s1 = w1; s2 = w2;
      @(negedge clk); start = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk); #1;
         check($sformatf("%s valid c%0d", tag, i), weight_valid, 1'b1);
         check($sformatf("%s ready c%0d", tag, i), weight_ready, 1'b0);
         check($sformatf("%s w1 hold c%0d", tag, i), w1, s1);
         check($sformatf("%s w2 hold c%0d", tag, i), w2, s2);
      end
      @(negedge clk); start = 1'b0; prepare = 1'b0;
      @(posedge clk); #1;
      check({tag, " valid off"}, weight_valid, 1'b0);
      check({tag, " ready off"}, weight_ready, 1'b0);
   endtask

   task automatic drop_prepare(input string tag);
      @(negedge clk); prepare = 1'b0;
      @(posedge clk); #1;
      check({tag, " ready drop"}, weight_ready, 1'b0);
   endtask

   task automatic pulse_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
   endtask

   initial begin
      logic [BW-1:0] s1, s2, e1;
      int rd_after, rdy_after, rd_before;
      int unsigned b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst rd_en", mem_rd_en, 1'b0);
      check("rst addr", mem_addr, '0);
      check("rst ready", weight_ready, 1'b0);
      check("rst valid", weight_valid, 1'b0);
      check("rst w1", w1, '0);
      check("rst w2", w2, '0);
      check("rst err", err, 1'b0);
      reset = 1'b0;

      // Worked example: addrs 9..17 and 27..35, data = addr & 0xFF
      mem_mul = 1; mem_add = 0;
      do_fetch(2, 4, 0, 1, 1, "spec");
      do_active(4, "spec act");

      // Bank 2 out of range: 9 reads, w2 zero-filled
      do_fetch(2, 3, 2, 3, 1, "skip");
      drop_prepare("skip");

      // Abort: prepare seen low at edge 5; returns captured at edges 3,4 are kept
      mem_mul = 7; mem_add = 3;
      s1 = w1; s2 = w2;
      b1 = kbase(0, 2, 1);
      @(negedge clk);
      total_id = 4'd2; total_od = 8'd4; od1 = 8'd0; od2 = 8'd1; id = 4'd1;
      prepare = 1'b1;
      @(posedge clk);
      rd_before = 0;
      for (int n = 1; n <= 4; n++) begin
         @(posedge clk); #1;
         rd_before += int'(mem_rd_en);
      end
      check("abort rd before", rd_before, 4);
      @(negedge clk); prepare = 1'b0;
      rd_after = 0; rdy_after = 0;
      for (int n = 5; n <= 30; n++) begin
         @(posedge clk); #1;
         rd_after  += int'(mem_rd_en);
         rdy_after += int'(weight_ready);
      end
      check("abort rd after", rd_after, 0);
      check("abort ready", rdy_after, 0);
      e1 = s1;
      for (int j = 0; j < 5 - 3; j++) e1[j*DW +: DW] = mem_word(b1 + j);
      check("abort w1", w1, e1);
      check("abort w2", w2, s2);
      check("abort err", err, 1'b0);
      // Back in IDLE: an immediate refetch keeps nominal latency
      do_fetch(2, 4, 0, 1, 1, "refetch");
      drop_prepare("refetch");

      // Randomized fetches
      for (int it = 0; it < 6; it++) begin
         mem_mul = $urandom | 1; mem_add = $urandom;
         do_fetch($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 15), $sformatf("rnd%0d", it));
         if ($urandom_range(0, 1) == 1) do_active($urandom_range(1, 6), $sformatf("rnd%0d act", it));
         else                           drop_prepare($sformatf("rnd%0d", it));
      end

      // Stray rvalid in IDLE: sticky error, FSM idle
      @(negedge clk); stray_rv = 1'b1;
      @(posedge clk); #1;
      check("stray err", err, 1'b1);
      @(negedge clk); stray_rv = 1'b0;
      @(posedge clk); #1;
      check("stray err sticky", err, 1'b1);
      check("stray rd_en", mem_rd_en, 1'b0);
      check("stray ready", weight_ready, 1'b0);
      pulse_reset();
      #1 check("err cleared", err, 1'b0);

      // Start in IDLE: error, then a normal fetch still works
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("start idle err", err, 1'b1);
      check("start idle valid", weight_valid, 1'b0);
      exp_err = 1'b1;
      mem_mul = 3; mem_add = 1;
      do_fetch(5, 10, 4, 7, 2, "post err");
      drop_prepare("post err");

      // Reset asserted mid-FETCH clears everything immediately
      @(negedge clk);
      total_id = 4'd3; total_od = 8'd9; od1 = 8'd1; od2 = 8'd2; id = 4'd0;
      prepare = 1'b1;
      @(posedge clk);
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("midrst rd_en", mem_rd_en, 1'b0);
      check("midrst addr", mem_addr, '0);
      check("midrst w1", w1, '0);
      check("midrst w2", w2, '0);
      check("midrst err", err, 1'b0);
      check("midrst ready", weight_ready, 1'b0);
      prepare = 1'b0;
      @(negedge clk); reset = 1'b0;
      exp_err = 1'b0;
      do_fetch(3, 9, 1, 2, 0, "after rst");
      do_active(2, "after rst act");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule
